// File: rtl/dot_pkg.sv
// dot_pkg: shared grid constants, tracker state type and tile-to-bit mapping
// for the 12x12 dot map. Used by dot_tracker and the renderer.
package dot_pkg;

  localparam int GRID_W     = 12;
  localparam int GRID_H     = 12;
  localparam int DOT_BITS   = 144;
  localparam int DOT_POINTS = 10;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PLAY,
    CLEAR
  } dot_state_t;

  // Row 0 is the most significant 12-bit group; column 0 is the group's MSB.
  function automatic logic [7:0] tile_index(input logic [3:0] row, input logic [3:0] col);
    int i;
    i = DOT_BITS - 1 - GRID_W * int'(row) - int'(col);
    return 8'(i);
  endfunction

endpackage

// File: rtl/dot_tile_addr.sv
// dot_tile_addr: combinational (row, col) -> dot-map bit index plus in-range
// flag. Out-of-range tiles report index 0 with in_range low.
module dot_tile_addr
  import dot_pkg::*;
#(
  parameter int GRID_W = dot_pkg::GRID_W,
  parameter int GRID_H = dot_pkg::GRID_H
) (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [7:0] idx,
  output logic       in_range
);

  // Range-check the tile and gate the index so it never points off the map.
  always_comb begin
    in_range = (32'(row) < GRID_H) && (32'(col) < GRID_W);
    idx      = in_range ? tile_index(row, col) : '0;
  end

endmodule

// File: rtl/dot_tracker.sv
// dot_tracker: live dot map for the current level. Captures the level start
// map on load, counts its dots one bit per cycle, then clears dots as Pac-Man
// eats them and pulses level_clear when the map empties.
// Optional feature macro: DOT_SCORE_EN enables the saturating score
// accumulator; without it score is tied to zero.
module dot_tracker
  import dot_pkg::*;
#(
  parameter int GRID_W     = dot_pkg::GRID_W,
  parameter int GRID_H     = dot_pkg::GRID_H,
  parameter int DOT_POINTS = dot_pkg::DOT_POINTS
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                load,
  input  logic [DOT_BITS-1:0] dot_starts,
  input  logic                pac_valid,
  input  logic [3:0]          pac_row,
  input  logic [3:0]          pac_col,
  output logic [DOT_BITS-1:0] dot_map,
  output logic [7:0]          dots_left,
  output logic                ready,
  output logic                eat_pulse,
  output logic                level_clear,
  output logic [15:0]         score
);

  dot_state_t state;
  logic [7:0] scan_idx;
  logic [7:0] addr_idx;
  logic       addr_ok;
  logic [7:0] count_sum;
  logic       eat_fire;

  dot_tile_addr #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_addr (
    .row      (pac_row),
    .col      (pac_col),
    .idx      (addr_idx),
    .in_range (addr_ok)
  );

  // Running count during the scan, and the qualified eat event (load wins).
  always_comb begin
    count_sum = dots_left + {7'b0, dot_map[scan_idx]};
    eat_fire  = (state == PLAY) && pac_valid && addr_ok && dot_map[addr_idx] && !load;
  end

  // Tracker FSM: capture, serial dot count, play, cleared.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      dot_map     <= '0;
      dots_left   <= '0;
      scan_idx    <= '0;
      ready       <= 1'b0;
      eat_pulse   <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      eat_pulse   <= 1'b0;
      level_clear <= 1'b0;
      if (load) begin
        dot_map   <= dot_starts;
        dots_left <= '0;
        scan_idx  <= '0;
        ready     <= 1'b0;
        state     <= COUNT;
      end else begin
        case (state)
          COUNT: begin
            dots_left <= count_sum;
            scan_idx  <= scan_idx + 8'd1;
            if (scan_idx == 8'(DOT_BITS - 1)) begin
              if (count_sum != '0) begin
                state <= PLAY;
                ready <= 1'b1;
              end else begin
                state       <= CLEAR;
                level_clear <= 1'b1;
              end
            end
          end
          PLAY: begin
            if (eat_fire) begin
              dot_map[addr_idx] <= 1'b0;
              dots_left         <= dots_left - 8'd1;
              eat_pulse         <= 1'b1;
              if (dots_left == 8'd1) begin
                state       <= CLEAR;
                ready       <= 1'b0;
                level_clear <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DOT_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + 17'(DOT_POINTS);

  // Saturating score accumulator; load leaves it untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_q <= '0;
    end else if (eat_fire) begin
      score_q <= score_sum[16] ? '1 : score_sum[15:0];
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_dot_tracker.sv
// tb_dot_tracker: directed test of dot_tracker against a tile-level model of
// the dot map, plus hand-computed literal expectations.
module tb_dot_tracker;

`ifdef DOT_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         load;
  logic [143:0] dot_starts;
  logic         pac_valid;
  logic [3:0]   pac_row;
  logic [3:0]   pac_col;
  logic [143:0] dot_map;
  logic [7:0]   dots_left;
  logic         ready;
  logic         eat_pulse;
  logic         level_clear;
  logic [15:0]  score;

  dot_tracker dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .load        (load),
    .dot_starts  (dot_starts),
    .pac_valid   (pac_valid),
    .pac_row     (pac_row),
    .pac_col     (pac_col),
    .dot_map     (dot_map),
    .dots_left   (dots_left),
    .ready       (ready),
    .eat_pulse   (eat_pulse),
    .level_clear (level_clear),
    .score       (score)
  );

  always #5 Clk = ~Clk;

  int passn = 0;
  int total = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passn++;
  endtask

  // Tile-level model: a grid of dots, a count-phase timer and a running tally.
  bit [143:0] m_map;
  int         m_left;
  int         m_cnt;
  bit         m_ready;
  bit         m_eat;
  bit         m_clr;
  int         m_score;

  always @(posedge Clk) begin
    int idx;
    if (Reset) begin
      m_map = '0; m_left = 0; m_cnt = 0; m_ready = 0; m_eat = 0; m_clr = 0; m_score = 0;
    end else begin
      m_eat = 0;
      m_clr = 0;
      if (load) begin
        m_map = dot_starts; m_left = 0; m_cnt = 144; m_ready = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_left = $countones(m_map);
          if (m_left > 0) m_ready = 1;
          else m_clr = 1;
        end
      end else if (m_ready && pac_valid && pac_row < 12 && pac_col < 12) begin
        idx = 143 - 12 * int'(pac_row) - int'(pac_col);
        if (m_map[idx]) begin
          m_map[idx] = 1'b0;
          m_left--;
          m_eat = 1;
          m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
          if (m_left == 0) begin
            m_ready = 0;
            m_clr = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model; the count is meaningful only once the scan ends.
  always @(negedge Clk) begin
    if (started) begin
      chk("map", dot_map, m_map);
      chk("ready", ready, m_ready);
      chk("eat_pulse", eat_pulse, m_eat);
      chk("level_clear", level_clear, m_clr);
      chk("score", score, SCORE_ON ? m_score : 0);
      if (m_cnt == 0) chk("dots_left", dots_left, m_left);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [143:0] defmap;
  int tr[11] = '{4, 4, 4, 5, 5, 6, 6, 7, 7, 7, 7};
  int tc[11] = '{5, 6, 7, 4, 7, 4, 7, 4, 5, 6, 7};

  initial begin
    Reset = 1'b1; load = 1'b0; dot_starts = '0; pac_valid = 1'b0; pac_row = '0; pac_col = '0;
    defmap = '0;
    defmap[143-12*4 -: 12] = 12'h0F0;
    defmap[143-12*5 -: 12] = 12'h090;
    defmap[143-12*6 -: 12] = 12'h090;
    defmap[143-12*7 -: 12] = 12'h0F0;

    step(); step();
    started = 1'b1;
    Reset = 1'b0;
    step();
    chk("rst_map", dot_map, '0);
    chk("rst_left", dots_left, 0);
    chk("rst_ready", ready, 0);
    chk("rst_score", score, 0);

    // Default level load and count.
    dot_starts = defmap; load = 1'b1;
    step();
    load = 1'b0;
    chk("load_map", dot_map, defmap);
    repeat (143) step();
    chk("ready_t144", ready, 0);
    step();
    chk("ready_t145", ready, 1);
    chk("count12", dots_left, 12);

    // First eat and repeat on the same tile.
    pac_valid = 1'b1; pac_row = 4; pac_col = 4;
    step();
    pac_valid = 1'b0;
    chk("bit91", dot_map[91], 0);
    chk("left11", dots_left, 11);
    chk("eat1", eat_pulse, 1);
    chk("score10", score, SCORE_ON ? 10 : 0);
    step();
    chk("eat_off", eat_pulse, 0);
    pac_valid = 1'b1;
    step();
    pac_valid = 1'b0;
    chk("repeat_left", dots_left, 11);
    chk("repeat_eat", eat_pulse, 0);

    // Empty tile and out-of-range tile.
    pac_valid = 1'b1; pac_row = 5; pac_col = 5;
    step();
    chk("empty_eat", eat_pulse, 0);
    pac_row = 12; pac_col = 3;
    step();
    pac_valid = 1'b0;
    chk("oor_eat", eat_pulse, 0);
    chk("oor_left", dots_left, 11);

    // Remaining 11 dots back to back.
    for (int i = 0; i < 11; i++) begin
      pac_valid = 1'b1; pac_row = 4'(tr[i]); pac_col = 4'(tc[i]);
      step();
      chk("b2b_eat", eat_pulse, 1);
      chk("b2b_clr", level_clear, (i == 10));
    end
    pac_valid = 1'b0;
    chk("all_left", dots_left, 0);
    chk("all_ready", ready, 0);
    step();
    chk("clr_once", level_clear, 0);
    chk("score120", score, SCORE_ON ? 120 : 0);

    // All-zero map.
    dot_starts = '0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (143) step();
    chk("zero_clr_early", level_clear, 0);
    step();
    chk("zero_clr", level_clear, 1);
    chk("zero_ready", ready, 0);
    step();
    chk("zero_clr_off", level_clear, 0);

    // Reset in the middle of the scan.
    dot_starts = defmap; load = 1'b1;
    step();
    load = 1'b0;
    repeat (70) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_left", dots_left, 0);
    chk("midrst_map", dot_map, '0);
    chk("midrst_ready", ready, 0);

    // Load during play collides with an eat: load wins.
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (144) step();
    chk("play_ready", ready, 1);
    load = 1'b1; pac_valid = 1'b1; pac_row = 4; pac_col = 4;
    step();
    load = 1'b0; pac_valid = 1'b0;
    chk("collide_map", dot_map, defmap);
    chk("collide_eat", eat_pulse, 0);
    repeat (146) step();
    chk("final_left", dots_left, 12);

    $display("%0d/%0d checks passed", passn, total);
    $finish;
  end

endmodule
